data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Handshaked fixed-latency word memory for the core's data load/store port.
// One request in flight; byte-masked stores, full-word loads, error on bad address.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WIDX_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
  } req_t;

  state_t            state;
  state_t            state_nx;
  req_t              lat;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       mem [DEPTH];
  logic [WIDX_W-1:0] widx;
  logic [IDX_W-1:0]  idx;
  logic              fire;
  logic              done;
  logic              err;
  logic              commit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (req_valid) state_nx = WAIT;
      WAIT: if (cnt == '0) state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): req_ready = 1'b1;
      (state == RESP): rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign widx   = lat.addr[ADDR_W-1:2];
  assign idx    = widx[IDX_W-1:0];
  assign err    = (lat.addr[1:0] != 2'b00)
               || (widx >= WIDX_W'(DEPTH));
  assign fire   = req_valid && req_ready;
  assign done   = (state == WAIT) && (cnt == '0);
  assign commit = done && lat.write && !err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat <= '0;
      cnt <= '0;
    end else if (fire) begin
      lat <= '{write: req_write,
               addr:  req_addr,
               wdata: req_wdata,
               be:    req_be};
      cnt <= CNT_W'(LATENCY - 1);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Loads see the array as it stands before this edge's commit,
  // which is fine: only one access is ever in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (done) begin
      rsp_err   <= err;
      rsp_rdata <= (err || lat.write) ? '0 : mem[idx];
    end else if (state == RESP && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lat.be[i]) begin
          mem[idx][8*i +: 8] <= lat.wdata[8*i +: 8];
        end
      end
    end
  end

endmodule
